// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder
//   Source end of the CNN pixel stream. A host loads one image into an
//   internal buffer while the block is idle; a start pulse replays it in
//   raster order, one pixel per cycle, with a programmable idle gap between
//   rows. The downstream pipeline has no back-pressure, so pacing is owned
//   entirely by this block.
//
//   Handshake: there is no ready. A beat is transferred on every rising
//   clock edge where valid_out=1; sof/eol/eof are only meaningful while
//   valid_out=1. pixel_out holds its last value while valid_out=0.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/wr_data  host buffer write (accepted only when idle)
//   img_width/img_height/row_gap  frame configuration, latched on start
//   start, abort        frame request / frame termination
//   valid_out, pixel_out, sof, eol, eof  pixel stream
//   busy, done, cfg_err status (done and cfg_err are one-cycle pulses)
module pixel_stream_feeder #(
  parameter int MAX_W  = 32,
  parameter int MAX_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  input  logic [3:0]        row_gap,
  input  logic              start,
  input  logic              abort,
  output logic              valid_out,
  output logic [7:0]        pixel_out,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int DEPTH = MAX_W * MAX_H;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  state_e            state_q;
  logic [7:0]        col_q;
  logic [7:0]        row_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        gap_cnt_q;
  logic [7:0]        w_q;
  logic [7:0]        h_q;
  logic [3:0]        gap_q;

  logic              valid_q;
  logic [7:0]        pixel_q;
  logic              sof_q;
  logic              eol_q;
  logic              eof_q;
  logic              busy_q;
  logic              done_q;
  logic              cfg_err_q;

  logic [7:0]        mem [DEPTH];

  logic              cfg_ok;
  logic              last_col;
  logic              last_row;
  logic              wr_ok;

  assign cfg_ok = (img_width  >= 8'd3) && (int'(img_width)  <= MAX_W) &&
                  (img_height >= 8'd3) && (int'(img_height) <= MAX_H);

  assign last_col = (col_q == w_q - 8'd1);
  assign last_row = (row_q == h_q - 8'd1);

  // Host writes only land while idle; a start in the same cycle still sees
  // the data because the first read is issued one cycle later.
  assign wr_ok = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_A);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer. The read issued in STREAM lands in pixel_q on the same
  // edge that raises valid_q, so data and markers stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= 8'd0;
      row_q     <= 8'd0;
      addr_q    <= '0;
      gap_cnt_q <= 4'd0;
      w_q       <= 8'd0;
      h_q       <= 8'd0;
      gap_q     <= 4'd0;
      valid_q   <= 1'b0;
      pixel_q   <= 8'd0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q     <= img_width;
              h_q     <= img_height;
              gap_q   <= row_gap;
              col_q   <= 8'd0;
              row_q   <= 8'd0;
              addr_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= STREAM;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            pixel_q <= mem[addr_q];
            valid_q <= 1'b1;
            sof_q   <= (row_q == 8'd0) && (col_q == 8'd0);
            eol_q   <= last_col;
            eof_q   <= last_col && last_row;
            addr_q  <= addr_q + ADDR_W'(1);
            if (last_col) begin
              col_q <= 8'd0;
              if (last_row) begin
                state_q <= FLUSH;
              end else begin
                row_q <= row_q + 8'd1;
                if (gap_q != 4'd0) begin
                  gap_cnt_q <= gap_q;
                  state_q   <= GAP;
                end
              end
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            // Counts gap_q..1, giving exactly gap_q idle cycles.
            gap_cnt_q <= gap_cnt_q - 4'd1;
            if (gap_cnt_q == 4'd1) begin
              state_q <= STREAM;
            end
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= !abort;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out = valid_q;
  assign pixel_out = pixel_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
module tb_pixel_stream_feeder;

  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = 8'd0;
  logic [7:0]        img_width = 8'd0;
  logic [7:0]        img_height = 8'd0;
  logic [3:0]        row_gap = 4'd0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              valid_out;
  logic [7:0]        pixel_out;
  logic              sof;
  logic              eol;
  logic              eof;
  logic              busy;
  logic              done;
  logic              cfg_err;

  pixel_stream_feeder #(.MAX_W(32), .MAX_H(32), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .img_width(img_width), .img_height(img_height), .row_gap(row_gap),
    .start(start), .abort(abort),
    .valid_out(valid_out), .pixel_out(pixel_out),
    .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- model + scoreboard ----------------
  logic [7:0]  model_mem [1024];
  logic [10:0] exp_q[$];   // {sof, eol, eof, pixel}
  int          done_cnt = 0;

  // Injection knobs used by run_frame
  bit          pre_wr = 0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]  pre_data = 8'd0;
  bit          inject = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("pixel_flags", {21'd0, sof, eol, eof, pixel_out}, {21'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_px(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({(r == 0 && c == 0), (c == w - 1), (r == h - 1 && c == w - 1),
                         model_mem[r * w + c]});
  endtask

  // Streams one frame, checking cycle-exact valid/busy/done timing; pixel
  // values and markers are compared by the scoreboard monitor.
  task automatic run_frame(input int w, input int h, input int g);
    int len;
    int d0;
    bit ev;
    len = h * w + (h - 1) * g;
    d0 = done_cnt;
    @(negedge clk);
    img_width = 8'(w); img_height = 8'(h); row_gap = 4'(g); start = 1'b1;
    if (pre_wr) begin
      wr_en = 1'b1; wr_addr = pre_addr; wr_data = pre_data;
      model_mem[pre_addr] = pre_data;
    end
    push_frame(w, h);
    @(negedge clk);  // k = 1
    start = 1'b0; wr_en = 1'b0; pre_wr = 0;
    chk("busy_k1", busy, 1'b1);
    chk("valid_k1", valid_out, 1'b0);
    for (int k = 2; k <= len + 1; k++) begin
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      if (inject && k == 5) begin
        wr_en = 1'b1; wr_addr = ADDR_W'(3); wr_data = 8'h80;
        start = 1'b1; img_width = 8'd3;
      end
      ev = ((k - 2) % (w + g)) < w;
      chk("valid_pattern", valid_out, ev);
      chk("busy_frame", busy, 1'b1);
      chk("done_early", done, 1'b0);
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0; inject = 0;
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("valid_end", valid_out, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("busy_after", busy, 1'b0);
    end
    chk("done_count", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic reject(input int w, input int h);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    img_width = 8'(w); img_height = 8'(h); row_gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1'b1);
    chk("reject_busy", busy, 1'b0);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("reject_valid", valid_out, 1'b0);
      chk("reject_busy2", busy, 1'b0);
    end
    chk("reject_no_done", done_cnt - d0, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {24'd0, valid_out, sof, eol, eof, busy, done, cfg_err, 1'b0}, 32'd0);
    chk(tag, {24'd0, pixel_out}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    #1;
    check_outputs_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic 5x5, values 0..24
    for (int i = 0; i < 25; i++) write_px(i, 8'(i));
    run_frame(5, 5, 0);

    // Row gap 4x3, gap 2, random data
    for (int i = 0; i < 12; i++) write_px(i, 8'($urandom_range(0, 255)));
    run_frame(4, 3, 2);

    // Config reject
    reject(2, 5);
    reject(5, 33);

    // Abort on the 10th pixel of an 8x8 frame
    for (int i = 0; i < 64; i++) write_px(i, 8'($urandom_range(0, 255)));
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      img_width = 8'd8; img_height = 8'd8; row_gap = 4'd0; start = 1'b1;
      push_frame(8, 8);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);  // k = 11: pixel 9 on the output
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", valid_out, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_remaining", exp_q.size(), 54);
      exp_q.delete();
      repeat (10) begin
        @(negedge clk);
        chk("abort_quiet", valid_out, 1'b0);
      end
      chk("abort_no_done", done_cnt - d0, 0);
    end
    run_frame(8, 8, 0);

    // Write lockout and start-while-busy
    write_px(3, 8'h11);
    inject = 1;
    run_frame(5, 5, 1);
    run_frame(5, 5, 1);

    // Asynchronous reset at pixel 7
    for (int i = 0; i < 25; i++) write_px(i, 8'($urandom_range(0, 255)));
    @(negedge clk);
    img_width = 8'd5; img_height = 8'd5; row_gap = 4'd0; start = 1'b1;
    push_frame(5, 5);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);  // k = 9: pixel 7 on the output
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    chk("reset_remaining", exp_q.size(), 17);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) write_px(i, 8'($urandom_range(0, 255)));
    run_frame(5, 5, 0);

    // Signed extremes; address 1 is written in the same cycle as start
    for (int i = 0; i < 9; i++) write_px(i, 8'($urandom_range(0, 255)));
    write_px(0, 8'h80);
    pre_wr = 1; pre_addr = ADDR_W'(1); pre_data = 8'h7F;
    run_frame(3, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_stream_feeder.md
Name: pixel_stream_feeder

Overview:
- Source end of the CNN pixel stream. It holds one image in an internal buffer that a host loads word by word.
- On a start pulse it replays the image in raster order as a valid/pixel stream that the convolution pipeline's pixel input consumes directly. It also emits row and frame markers.
- The pipeline has no ready signal, so pacing is fixed by the feeder: one pixel per cycle, plus a programmable idle gap between rows.

Parameters:
- MAX_W, 32, maximum image width in pixels.
- MAX_H, 32, maximum image height in pixels.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= MAX_W*MAX_H.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_addr  in  ADDR_W  host buffer write address (linear, row*width+col).
- wr_data  in  8  signed pixel to store.
- img_width  in  8  frame width, sampled on accepted start.
- img_height  in  8  frame height, sampled on accepted start.
- row_gap  in  4  idle cycles inserted after each row except the last; sampled on accepted start.
- start  in  1  one-cycle request to stream one frame.
- abort  in  1  terminate the current frame.
- valid_out  out  1  pixel_out is valid this cycle.
- pixel_out  out  8  signed pixel.
- sof  out  1  first pixel of frame; qualified by valid_out.
- eol  out  1  last pixel of a row; qualified by valid_out.
- eof  out  1  last pixel of frame; qualified by valid_out.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on normal frame completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async, rst_n=0): all outputs go to 0, state to IDLE, counters to 0. Buffer contents are undefined after reset.
- Buffer: single-port-write, single-port-read synchronous RAM.
  - A write occurs when wr_en=1 and state==IDLE.
  - wr_en is ignored while busy=1; buffer contents stay unchanged.
  - Writes to addresses >= MAX_W*MAX_H are dropped.
  - Read latency is 1 cycle.
- State machine has states IDLE, STREAM, GAP, FLUSH.
- IDLE:
  - start=1 with 3<=img_width<=MAX_W and 3<=img_height<=MAX_H: latch the configuration, set busy=1 on the next edge, go to STREAM, address 0.
  - start=1 with any other configuration: cfg_err=1 for one cycle, stay in IDLE, busy remains 0.
  - start and wr_en in the same cycle: the write completes first. Data written that cycle is visible to the frame.
- STREAM:
  - Issue one read address per cycle; col and row counters and the linear address increment by one.
  - At col==W-1 and row<H-1: if gap>0 go to GAP, otherwise stay in STREAM and start the next row.
  - At col==W-1 and row==H-1: go to FLUSH.
- GAP: issue no reads for exactly row_gap cycles, then return to STREAM.
- FLUSH: one cycle that drains the read pipeline, then go to IDLE. done=1 and busy=0 take effect on that edge.
- Output pipeline: valid_out, sof, eol and eof are registered and delayed one cycle to align with RAM data.
  - First valid_out appears 2 cycles after the cycle in which start was sampled.
  - pixel_out holds its last value when valid_out=0.
- Frame duration: H*W + (H-1)*gap cycles of stream activity. done asserts on the cycle immediately after the eof pixel.
- start while busy=1 is ignored (no error, no restart).
- abort=1 in any non-IDLE state:
  - Next edge: state IDLE, busy=0, valid_out=0, and any in-flight read is discarded.
  - done is not pulsed.
  - abort takes priority over a same-cycle transition.
  - abort in IDLE has no effect.
- Configuration inputs that change mid-frame have no effect, because they were latched at start.
- Width rules: address arithmetic uses ADDR_W bits. The counters are 8 bits. Pixels are passed through unmodified.

Test Plan:
- Basic frame: load 5x5 buffer with values 0..24, img_width=5, img_height=5, row_gap=0, start -> 25 consecutive valid_out starting 2 cycles after start.
  - pixel_out = 0..24, sof on pixel 0, eol on 4/9/14/19/24, eof on 24.
  - done 1 cycle after pixel 24; busy high for 26 cycles.
- Row gap: 4x3 frame, row_gap=2 -> valid_out pattern 1111 00 1111 00 1111 (16 cycles), no gap after the last row, done follows.
- Config reject: start with img_width=2 -> cfg_err pulse, busy stays 0, no valid_out. start with img_height=MAX_H+1 -> same response.
- Abort: 8x8 frame, assert abort on the 10th valid pixel -> valid_out=0 from the next cycle, busy=0, done never pulses.
  - A following start streams a full frame correctly from pixel 0.
- Write lockout and restart: during a frame, wr_en to address 3 with value -128 -> buffer unchanged, verified by the next frame's pixel 3.
  - start during busy -> ignored; exactly one done is produced.
- Reset mid-frame: deassert rst_n asynchronously at pixel 7 -> all outputs 0 immediately.
  - After release, a start with the reloaded buffer streams normally.
- Signed extremes: buffer holds -128 and 127 at addresses 0 and 1 -> pixel_out reproduces 8'h80 and 8'h7F exactly.
